// File: rtl/stream_demux1_4_if.sv
// Stream bundle for the 1-to-4 demux.
// One producer-facing input channel and four consumer-facing output slots.
interface stream_demux1_4_if #(
  parameter int unsigned DATA_W = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_W-1:0]     in_data;
  logic                  in_last;
  logic [1:0]            in_sel;
  logic [3:0]            out_valid;
  logic [3:0]            out_ready;
  logic [4*DATA_W-1:0]   out_data;
  logic [3:0]            out_last;

  // Producer and consumers (testbench / surrounding logic)
  modport master (
    output in_valid, in_data, in_last, in_sel, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  // The demux itself
  modport slave (
    input  in_valid, in_data, in_last, in_sel, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/stream_demux1_4.sv
// 1-to-4 packet stream demultiplexer.
// The route is taken from in_sel on a packet's first beat and locked until
// its last beat. Each output channel has a one-entry registered slot, and a
// wrapping accepted-packet counter is kept per channel.
module stream_demux1_4 #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  stream_demux1_4_if.slave     bus,
  output logic                 busy,
  output logic [4*CNT_W-1:0]   pkt_cnt
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state;
  logic [1:0]          lock_sel;
  logic [1:0]          route;
  logic                in_ready;
  logic                accept;
  logic [3:0]          out_valid;
  logic [3:0]          out_last;
  logic [4*DATA_W-1:0] out_data;

  // Route select and handshake; a slot draining this cycle can take a new beat
  always_comb begin
    route    = (state == BUSY) ? lock_sel : bus.in_sel;
    in_ready = rst_n && (!out_valid[route] || bus.out_ready[route]);
    accept   = bus.in_valid && in_ready;
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.out_last  = out_last;
  assign busy          = (state == BUSY);

  // Packet-framing FSM, per-channel slots and packet counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      lock_sel  <= '0;
      out_valid <= '0;
      out_last  <= '0;
      out_data  <= '0;
      pkt_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && !bus.in_last) begin
            state    <= BUSY;
            lock_sel <= bus.in_sel;
          end
        end
        BUSY: begin
          if (accept && bus.in_last) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      for (int unsigned i = 0; i < 4; i++) begin
        if (accept && route == 2'(i)) begin
          out_data[i*DATA_W +: DATA_W] <= bus.in_data;
          out_last[i]                  <= bus.in_last;
          out_valid[i]                 <= 1'b1;
          if (bus.in_last) begin
            pkt_cnt[i*CNT_W +: CNT_W] <= pkt_cnt[i*CNT_W +: CNT_W] + CNT_W'(1);
          end
        end else if (bus.out_ready[i]) begin
          out_valid[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_stream_demux1_4.sv
// Directed testbench for stream_demux1_4.
module tb_stream_demux1_4;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 8;

  logic                clk;
  logic                rst_n;
  logic                busy;
  logic [4*CNT_W-1:0]  pkt_cnt;

  int unsigned vectors;
  int unsigned miscompares;

  stream_demux1_4_if #(.DATA_W(DATA_W)) bus ();

  stream_demux1_4 #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .busy    (busy),
    .pkt_cnt (pkt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] sel, input logic [7:0] d, input logic l);
    bus.in_valid = v;
    bus.in_sel   = sel;
    bus.in_data  = d;
    bus.in_last  = l;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n         = 1'b0;
    bus.out_ready = 4'hF;
    drive(1'b1, 2'd0, 8'h55, 1'b1);

    // Reset held for two edges with in_valid asserted
    tick();
    tick();
    chk("rst_out_valid", {28'd0, bus.out_valid}, 32'h0);
    chk("rst_in_ready",  {31'd0, bus.in_ready},  32'h0);
    chk("rst_pkt_cnt",   pkt_cnt,                32'h0);
    chk("rst_busy",      {31'd0, busy},          32'h0);
    chk("rst_out_data",  bus.out_data,           32'h0);
    rst_n = 1'b1;
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    #1;
    chk("post_rst_in_ready", {31'd0, bus.in_ready}, 32'h1);

    // Idle input garbage must not change state
    drive(1'b0, 2'd2, 8'hFF, 1'b0);
    tick();
    chk("x_busy",      {31'd0, busy},          32'h0);
    chk("x_out_valid", {28'd0, bus.out_valid}, 32'h0);

    // Single-beat packets to channels 0..3 back to back
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'(i), 8'hA0 + 8'(i), 1'b1);
      #1;
      chk("sb_in_ready", {31'd0, bus.in_ready}, 32'h1);
      tick();
      chk("sb_out_valid", {28'd0, bus.out_valid}, 32'h1 << i);
      chk("sb_out_data",  {24'd0, bus.out_data[i*8 +: 8]}, 32'hA0 + 32'(i));
      chk("sb_out_last",  {31'd0, bus.out_last[i]}, 32'h1);
      chk("sb_busy",      {31'd0, busy}, 32'h0);
    end
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    tick();
    chk("sb_pkt_cnt",   pkt_cnt,                32'h01010101);
    chk("sb_drained",   {28'd0, bus.out_valid}, 32'h0);

    // Packet lock: sel changes on beats 2 and 3 are ignored
    drive(1'b1, 2'd2, 8'h11, 1'b0);
    tick();
    chk("lk1_valid", {28'd0, bus.out_valid}, 32'h4);
    chk("lk1_data",  {24'd0, bus.out_data[16 +: 8]}, 32'h11);
    chk("lk1_last",  {31'd0, bus.out_last[2]}, 32'h0);
    chk("lk1_busy",  {31'd0, busy}, 32'h1);
    drive(1'b1, 2'd1, 8'h22, 1'b0);
    tick();
    chk("lk2_valid", {28'd0, bus.out_valid}, 32'h4);
    chk("lk2_data",  {24'd0, bus.out_data[16 +: 8]}, 32'h22);
    chk("lk2_last",  {31'd0, bus.out_last[2]}, 32'h0);
    chk("lk2_busy",  {31'd0, busy}, 32'h1);
    drive(1'b1, 2'd3, 8'h33, 1'b1);
    tick();
    chk("lk3_valid", {28'd0, bus.out_valid}, 32'h4);
    chk("lk3_data",  {24'd0, bus.out_data[16 +: 8]}, 32'h33);
    chk("lk3_last",  {31'd0, bus.out_last[2]}, 32'h1);
    chk("lk3_busy",  {31'd0, busy}, 32'h0);
    chk("lk_pkt_cnt", pkt_cnt, 32'h01020101);
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    tick();

    // Backpressure on channel 1
    bus.out_ready = 4'b1101;
    drive(1'b1, 2'd1, 8'h5A, 1'b1);
    tick();
    chk("bp1_valid", {28'd0, bus.out_valid}, 32'h2);
    chk("bp1_data",  {24'd0, bus.out_data[8 +: 8]}, 32'h5A);
    drive(1'b1, 2'd1, 8'h6B, 1'b1);
    #1;
    chk("bp_stall_ready", {31'd0, bus.in_ready}, 32'h0);
    tick();
    chk("bp_hold_data",   {24'd0, bus.out_data[8 +: 8]}, 32'h5A);
    chk("bp_hold_valid",  {28'd0, bus.out_valid}, 32'h2);
    chk("bp_hold_ready",  {31'd0, bus.in_ready}, 32'h0);
    bus.out_ready = 4'hF;
    #1;
    chk("bp_release_ready", {31'd0, bus.in_ready}, 32'h1);
    tick();
    chk("bp2_data",  {24'd0, bus.out_data[8 +: 8]}, 32'h6B);
    chk("bp2_valid", {28'd0, bus.out_valid}, 32'h2);
    drive(1'b1, 2'd1, 8'h7C, 1'b1);
    #1;
    chk("bp3_ready", {31'd0, bus.in_ready}, 32'h1);
    tick();
    chk("bp3_data",  {24'd0, bus.out_data[8 +: 8]}, 32'h7C);
    chk("bp_pkt_cnt", pkt_cnt, 32'h01020401);
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    tick();

    // Reset in the middle of a packet to channel 0
    drive(1'b1, 2'd0, 8'hC1, 1'b0);
    tick();
    drive(1'b1, 2'd2, 8'hC2, 1'b0);
    tick();
    chk("mid_busy", {31'd0, busy}, 32'h1);
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_busy",  {31'd0, busy}, 32'h0);
    chk("mid_rst_valid", {28'd0, bus.out_valid}, 32'h0);
    chk("mid_rst_cnt",   pkt_cnt, 32'h0);
    drive(1'b1, 2'd3, 8'h3C, 1'b1);
    tick();
    chk("mid_new_valid", {28'd0, bus.out_valid}, 32'h8);
    chk("mid_new_data",  {24'd0, bus.out_data[24 +: 8]}, 32'h3C);
    chk("mid_new_busy",  {31'd0, busy}, 32'h0);

    // Counter wrap on channel 3: one packet already counted, 254 more -> 255
    for (int n = 0; n < 254; n++) begin
      drive(1'b1, 2'd3, 8'(n), 1'b1);
      #1;
      chk("wr_in_ready", {31'd0, bus.in_ready}, 32'h1);
      tick();
    end
    chk("wr_cnt_255", {24'd0, pkt_cnt[24 +: 8]}, 32'hFF);
    chk("wr_last_data", {24'd0, bus.out_data[24 +: 8]}, 32'hFD);
    drive(1'b1, 2'd3, 8'hEE, 1'b1);
    tick();
    chk("wr_cnt_0",   {24'd0, pkt_cnt[24 +: 8]}, 32'h0);
    chk("wr_others",  {8'd0, pkt_cnt[0 +: 24]}, 32'h0);
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    tick();
    chk("wr_drained", {28'd0, bus.out_valid}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stream_demux1_4.md
Name: stream_demux1_4

Overview:
- 1-to-4 packet stream demultiplexer with valid/ready handshakes on all ports.
- Routes each input packet to the output channel selected by in_sel, sampled on the packet's first beat.
- Each output channel has a one-entry registered slot.
- Sits downstream of a single producer and fans its traffic out to four consumers.
- Keeps a wrapping accepted-packet counter per channel.

Parameters:
- DATA_W, 8, width of one data beat.
- CNT_W, 8, width of each per-channel packet counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  demux can accept the input beat.
- in_data  input  DATA_W  input beat data.
- in_last  input  1  final beat of the packet.
- in_sel  input  2  destination channel; sampled only on the first beat of a packet.
- out_valid  output  4  per-channel slot valid; bit i is channel i.
- out_ready  input  4  per-channel consumer ready.
- out_data  output  4*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- out_last  output  4  per-channel last flag.
- busy  output  1  high while a multi-beat packet is in progress (state BUSY).
- pkt_cnt  output  4*CNT_W  channel i occupies bits [i*CNT_W +: CNT_W].

Behaviour:
- Reset: rst_n low at a clk edge clears the following.
  - out_valid=0, out_data=0, out_last=0, pkt_cnt=0.
  - State=IDLE, lock_sel=0.
  - A packet in flight is abandoned and slot contents are discarded.
  - in_ready is 0 while rst_n is low.
- Route selection: route = in_sel in IDLE; route = lock_sel in BUSY.
- in_ready = !out_valid[route] || out_ready[route].
  - Combinational; independent of in_valid.
  - A full slot that drains in the same cycle still accepts, so one beat per cycle is sustained.
- Accept: accept = in_valid && in_ready.
- State machine transitions:
  - IDLE, accept, in_last=0 -> BUSY; lock_sel <= in_sel.
  - IDLE, accept, in_last=1 -> stay IDLE (single-beat packet).
  - BUSY, accept, in_last=1 -> IDLE.
  - BUSY, any other case -> stay BUSY. in_sel is ignored while BUSY.
  - busy = (state==BUSY).
- Slot update per channel i, evaluated with this priority:
  - If accept && route==i: out_data[i] <= in_data, out_last[i] <= in_last, out_valid[i] <= 1.
  - Else if out_ready[i]: out_valid[i] <= 0; data and last hold their values.
  - Else: hold.
- Latency: a beat accepted at edge N is visible on channel route from edge N through the cycle after edge N (1 cycle).
- Output stability: while out_valid[i] && !out_ready[i], out_data[i] and out_last[i] are stable.
- Channel independence: channels not addressed are unaffected. Several channels may hold valid beats at once, and each drains independently.
- Counters: pkt_cnt[i] increments by 1 on each accept with in_last=1 and route==i.
  - Wraps modulo 2^CNT_W (255 -> 0 at the default width).
  - Non-last beats do not count.
- Backpressure: a stalled destination (slot full and out_ready low) holds in_ready=0. There is no head-of-line bypass to other channels.
- X rule: in_data, in_last and in_sel are don't-care when in_valid=0 and must not change state.

Test Plan:
- Reset: drive in_valid=1 with rst_n=0 for 2 cycles -> out_valid=4'b0000, in_ready=0, pkt_cnt all 0, busy=0. After release, in_ready=1.
- Single-beat packets: send in_sel=0..3 with in_data=8'hA0..8'hA3, in_last=1, all out_ready=1, back-to-back. Required response:
  - Each beat appears on channel in_sel 1 cycle after accept.
  - in_ready stays 1 throughout.
  - pkt_cnt=1,1,1,1 at the end.
  - busy stays 0.
- Packet lock: send 3 beats 8'h11, 8'h22, 8'h33 with in_sel=2 on beat 1, then in_sel=1 and in_sel=3 on beats 2 and 3, last on beat 3. Required response:
  - All three beats appear on channel 2; out_last[2]=1 only with 8'h33.
  - busy=1 after beat 1 and returns to 0 after beat 3.
  - pkt_cnt[2]=1; other counters 0.
- Backpressure: hold out_ready[1]=0 and send 2 beats to channel 1. Required response:
  - The first beat occupies the slot and out_data[1] holds that value.
  - in_ready=0 with the second beat pending.
  - Raise out_ready[1] -> the second beat is accepted in that same cycle (pass-through), and throughput resumes at 1 beat/cycle.
- Counter wrap: send 256 single-beat packets to channel 3 with CNT_W=8 -> pkt_cnt[3] reads 255 after 255 packets, then 0 after the 256th.
- Reset mid-packet: after 2 non-last beats to channel 0 (busy=1), pulse rst_n=0 for 1 cycle. Required response:
  - busy=0 and out_valid=0.
  - The next first beat with in_sel=3 routes to channel 3.
